// File: rtl/lpddr_cmd_arbiter.sv
// Arbitrates the single LPDDR MCB command port between one write and one read requester,
// issuing a command only when the whole burst can move through the data FIFOs.
module lpddr_cmd_arbiter #(
  parameter bit AUTO_PRECHARGE = 1'b0,
  parameter int FIFO_DEPTH     = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_req,
  input  logic [29:0] i_wr_addr,
  input  logic [5:0]  i_wr_bl,
  output logic        o_wr_ack,
  input  logic        i_rd_req,
  input  logic [29:0] i_rd_addr,
  input  logic [5:0]  i_rd_bl,
  output logic        o_rd_ack,
  input  logic [6:0]  i_wr_count,
  input  logic [6:0]  i_rd_count,
  output logic        o_cmd_clk,
  output logic        o_cmd_en,
  output logic [2:0]  o_cmd_instr,
  output logic [5:0]  o_cmd_bl,
  output logic [29:0] o_cmd_byte_addr,
  input  logic        i_cmd_full,
  input  logic        i_cmd_empty,
  output logic        o_last_rd,
  output logic        o_busy,
  output logic        o_idle,
  output logic        o_cmd_err
);

  localparam logic [7:0] LP_DEPTH = 8'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_cmd_en;
  logic        r_wr_ack;
  logic        r_rd_ack;
  logic [2:0]  r_cmd_instr;
  logic [5:0]  r_cmd_bl;
  logic [29:0] r_cmd_byte_addr;
  logic        r_last_rd;
  logic        r_busy;
  logic        r_idle;
  logic        r_cmd_err;

  logic        w_cmd_en_nxt;
  logic        w_wr_ack_nxt;
  logic        w_rd_ack_nxt;
  logic [2:0]  w_cmd_instr_nxt;
  logic [5:0]  w_cmd_bl_nxt;
  logic [29:0] w_cmd_byte_addr_nxt;
  logic        w_last_rd_nxt;
  logic        w_busy_nxt;
  logic        w_idle_nxt;
  logic        w_cmd_err_nxt;

  logic [6:0]  w_wr_need;
  logic        w_wr_ok;
  logic [7:0]  w_rd_need;
  logic [7:0]  w_rd_used;
  logic [7:0]  w_rd_room;
  logic        w_rd_ok;
  logic        w_grant;
  logic        w_grant_rd;
  logic [27:0] w_sel_addr;
  logic        w_unused;

  // A read FIFO reporting more than its depth is treated as having no room at all.
  assign w_wr_need = {1'b0, i_wr_bl} + 7'd1;
  assign w_wr_ok   = i_wr_req & (i_wr_count >= w_wr_need);
  assign w_rd_need = {2'b00, i_rd_bl} + 8'd1;
  assign w_rd_used = {1'b0, i_rd_count};
  assign w_rd_room = (w_rd_used > LP_DEPTH) ? 8'd0 : (LP_DEPTH - w_rd_used);
  assign w_rd_ok   = i_rd_req & (w_rd_room >= w_rd_need);

  // On a tie the side that did not win last time gets the port.
  assign w_grant    = (r_state == ST_IDLE) & ~i_cmd_full & (w_wr_ok | w_rd_ok);
  assign w_grant_rd = w_rd_ok & (~w_wr_ok | ~r_last_rd);
  assign w_sel_addr = w_grant_rd ? i_rd_addr[27:0] : i_wr_addr[27:0];

  // Top address bits fall off the byte-address shift.
  assign w_unused = ^{i_wr_addr[29:28], i_rd_addr[29:28]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_GAP;
      ST_GAP:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_en_nxt        = w_grant;
    w_wr_ack_nxt        = w_grant & ~w_grant_rd;
    w_rd_ack_nxt        = w_grant & w_grant_rd;
    w_cmd_instr_nxt     = r_cmd_instr;
    w_cmd_bl_nxt        = r_cmd_bl;
    w_cmd_byte_addr_nxt = r_cmd_byte_addr;
    w_last_rd_nxt       = r_last_rd;
    if (w_grant) begin
      w_cmd_instr_nxt     = {1'b0, AUTO_PRECHARGE, w_grant_rd};
      w_cmd_bl_nxt        = w_grant_rd ? i_rd_bl : i_wr_bl;
      w_cmd_byte_addr_nxt = {w_sel_addr, 2'b00};
      w_last_rd_nxt       = w_grant_rd;
    end
    w_busy_nxt    = (w_state_nxt != ST_IDLE);
    w_idle_nxt    = (w_state_nxt == ST_IDLE) & ~i_wr_req & ~i_rd_req & i_cmd_empty;
    w_cmd_err_nxt = r_cmd_err | (r_cmd_en & i_cmd_full);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd_en        <= 1'b0;
      r_wr_ack        <= 1'b0;
      r_rd_ack        <= 1'b0;
      r_cmd_instr     <= {1'b0, AUTO_PRECHARGE, 1'b0};
      r_cmd_bl        <= 6'd0;
      r_cmd_byte_addr <= 30'd0;
      r_last_rd       <= 1'b1;
      r_busy          <= 1'b0;
      r_idle          <= 1'b0;
      r_cmd_err       <= 1'b0;
    end else begin
      r_cmd_en        <= w_cmd_en_nxt;
      r_wr_ack        <= w_wr_ack_nxt;
      r_rd_ack        <= w_rd_ack_nxt;
      r_cmd_instr     <= w_cmd_instr_nxt;
      r_cmd_bl        <= w_cmd_bl_nxt;
      r_cmd_byte_addr <= w_cmd_byte_addr_nxt;
      r_last_rd       <= w_last_rd_nxt;
      r_busy          <= w_busy_nxt;
      r_idle          <= w_idle_nxt;
      r_cmd_err       <= w_cmd_err_nxt;
    end
  end

  assign o_cmd_clk       = i_clk;
  assign o_cmd_en        = r_cmd_en;
  assign o_wr_ack        = r_wr_ack;
  assign o_rd_ack        = r_rd_ack;
  assign o_cmd_instr     = r_cmd_instr;
  assign o_cmd_bl        = r_cmd_bl;
  assign o_cmd_byte_addr = r_cmd_byte_addr;
  assign o_last_rd       = r_last_rd;
  assign o_busy          = r_busy;
  assign o_idle          = r_idle;
  assign o_cmd_err       = r_cmd_err;

endmodule

// File: tb/tb_lpddr_cmd_arbiter.sv
// Scoreboard bench for lpddr_cmd_arbiter: two instances (AUTO_PRECHARGE 0 and 1) share
// the same stimulus, and a negedge monitor pops an expected command for every cmd_en.
module tb_lpddr_cmd_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wrReq, rdReq;
   logic [29:0] wrAddr, rdAddr;
   logic [5:0]  wrBl, rdBl;
   logic [6:0]  wrCount, rdCount;
   logic        cmdFull, cmdEmpty;

   logic        wrAck, rdAck, cmdClk, cmdEn, lastRd, busy, idle, cmdErr;
   logic [2:0]  cmdInstr;
   logic [5:0]  cmdBl;
   logic [29:0] cmdAddr;

   logic        apWrAck, apRdAck, apCmdClk, apCmdEn, apLastRd, apBusy, apIdle, apCmdErr;
   logic [2:0]  apCmdInstr;
   logic [5:0]  apCmdBl;
   logic [29:0] apCmdAddr;

   typedef struct {
      logic        isRd;
      logic [5:0]  bl;
      logic [29:0] addr;
   } cmdExp_t;

   cmdExp_t expQ[$];
   cmdExp_t monExp;
   int      vectors = 0;
   int      miscompares = 0;
   logic    prevEn = 1'b0;

   lpddr_cmd_arbiter #(.AUTO_PRECHARGE(1'b0), .FIFO_DEPTH(64)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wr_req(wrReq), .i_wr_addr(wrAddr), .i_wr_bl(wrBl), .o_wr_ack(wrAck),
      .i_rd_req(rdReq), .i_rd_addr(rdAddr), .i_rd_bl(rdBl), .o_rd_ack(rdAck),
      .i_wr_count(wrCount), .i_rd_count(rdCount),
      .o_cmd_clk(cmdClk), .o_cmd_en(cmdEn), .o_cmd_instr(cmdInstr), .o_cmd_bl(cmdBl),
      .o_cmd_byte_addr(cmdAddr), .i_cmd_full(cmdFull), .i_cmd_empty(cmdEmpty),
      .o_last_rd(lastRd), .o_busy(busy), .o_idle(idle), .o_cmd_err(cmdErr)
   );

   lpddr_cmd_arbiter #(.AUTO_PRECHARGE(1'b1), .FIFO_DEPTH(64)) dutAp (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wr_req(wrReq), .i_wr_addr(wrAddr), .i_wr_bl(wrBl), .o_wr_ack(apWrAck),
      .i_rd_req(rdReq), .i_rd_addr(rdAddr), .i_rd_bl(rdBl), .o_rd_ack(apRdAck),
      .i_wr_count(wrCount), .i_rd_count(rdCount),
      .o_cmd_clk(apCmdClk), .o_cmd_en(apCmdEn), .o_cmd_instr(apCmdInstr), .o_cmd_bl(apCmdBl),
      .o_cmd_byte_addr(apCmdAddr), .i_cmd_full(cmdFull), .i_cmd_empty(cmdEmpty),
      .o_last_rd(apLastRd), .o_busy(apBusy), .o_idle(apIdle), .o_cmd_err(apCmdErr)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Every comparison in the bench funnels through here so the counters stay honest.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives the full requester-side picture in one go.
   task automatic applyStimulus(input logic wr, input logic [29:0] wa, input logic [5:0] wb,
                                input logic [6:0] wc, input logic rd, input logic [29:0] ra,
                                input logic [5:0] rb, input logic [6:0] rc);
      wrReq = wr; wrAddr = wa; wrBl = wb; wrCount = wc;
      rdReq = rd; rdAddr = ra; rdBl = rb; rdCount = rc;
   endtask

   task automatic pushExp(input logic isRd, input logic [5:0] bl, input logic [29:0] addr);
      cmdExp_t e;
      e.isRd = isRd;
      e.bl   = bl;
      e.addr = addr;
      expQ.push_back(e);
   endtask

   // Counts rising edges until an ack is visible, giving up after 'limit' edges.
   task automatic waitGrant(input int limit, output int edges);
      edges = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
      end while (!(wrAck | rdAck) && edges < limit);
      if (!(wrAck | rdAck)) checkOutput("grant_timeout", 32'd0, 32'd1);
   endtask

   task automatic checkResetValues();
      checkOutput("rst_cmd_en", {cmdEn, apCmdEn}, 2'b00);
      checkOutput("rst_acks", {wrAck, rdAck, apWrAck, apRdAck}, 4'b0000);
      checkOutput("rst_cmd_bl", {cmdBl, apCmdBl}, 12'd0);
      checkOutput("rst_cmd_addr", cmdAddr, 30'd0);
      checkOutput("rst_ap_cmd_addr", apCmdAddr, 30'd0);
      checkOutput("rst_cmd_instr", {cmdInstr, apCmdInstr}, 6'b000_010);
      checkOutput("rst_last_rd", {lastRd, apLastRd}, 2'b11);
      checkOutput("rst_busy", {busy, apBusy}, 2'b00);
      checkOutput("rst_cmd_err", {cmdErr, apCmdErr}, 2'b00);
   endtask

   // Monitor: each cmd_en cycle must match the oldest queued command on both instances.
   always @(negedge clk) begin
      if (!rst_n) begin
         prevEn = 1'b0;
      end else begin
         checkOutput("cmd_en_back_to_back", {31'd0, prevEn & cmdEn}, 32'd0);
         checkOutput("ap_cmd_en", apCmdEn, cmdEn);
         if (cmdEn) begin
            if (expQ.size() == 0) begin
               checkOutput("cmd_unexpected", 32'd1, 32'd0);
            end else begin
               monExp = expQ.pop_front();
               checkOutput("cmd_instr", cmdInstr, {2'b00, monExp.isRd});
               checkOutput("ap_cmd_instr", apCmdInstr, {2'b01, monExp.isRd});
               checkOutput("cmd_bl", {cmdBl, apCmdBl}, {monExp.bl, monExp.bl});
               checkOutput("cmd_byte_addr", cmdAddr, monExp.addr);
               checkOutput("ap_cmd_byte_addr", apCmdAddr, monExp.addr);
               checkOutput("cmd_acks", {wrAck, rdAck, apWrAck, apRdAck},
                           {~monExp.isRd, monExp.isRd, ~monExp.isRd, monExp.isRd});
               checkOutput("last_rd", {lastRd, apLastRd}, {monExp.isRd, monExp.isRd});
               checkOutput("busy_issue", {busy, apBusy}, 2'b11);
            end
         end else begin
            checkOutput("ack_without_cmd", {wrAck, rdAck, apWrAck, apRdAck}, 4'b0000);
         end
         prevEn = cmdEn;
      end
   end

   initial begin
      int lat;
      rst_n = 1'b0;
      cmdFull = 1'b0;
      cmdEmpty = 1'b1;
      applyStimulus(1'b0, 30'd0, 6'd0, 7'd0, 1'b0, 30'd0, 6'd0, 7'd0);
      repeat (3) @(posedge clk);
      #1;
      $display("[TB] reset values");
      checkResetValues();
      checkOutput("cmd_clk", {cmdClk, apCmdClk}, {clk, clk});
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("idle_quiet", {idle, apIdle}, 2'b11);

      $display("[TB] write data check");
      applyStimulus(1'b1, 30'h100, 6'd15, 7'd15, 1'b0, 30'd0, 6'd0, 7'd0);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("wr_short_busy", busy, 1'b0);
      checkOutput("idle_req_pending", idle, 1'b0);
      pushExp(1'b0, 6'd15, 30'h400);
      wrCount = 7'd16;
      waitGrant(20, lat);
      checkOutput("wr_latency", lat, 32'd1);
      wrReq = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] read room check");
      applyStimulus(1'b0, 30'd0, 6'd0, 7'd0, 1'b1, 30'h2000, 6'd31, 7'd33);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("rd_full_busy", busy, 1'b0);
      pushExp(1'b1, 6'd31, 30'h8000);
      rdCount = 7'd32;
      waitGrant(20, lat);
      checkOutput("rd_latency", lat, 32'd1);
      rdReq = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] round robin from reset");
      rst_n = 1'b0;
      applyStimulus(1'b1, 30'h0AAA, 6'd3, 7'd4, 1'b1, 30'h0BBB, 6'd7, 7'd0);
      for (int i = 0; i < 3; i++) begin
         pushExp(1'b0, 6'd3, 30'h2AA8);
         pushExp(1'b1, 6'd7, 30'h2EEC);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      waitGrant(20, lat);
      checkOutput("rr_first_latency", lat, 32'd1);
      for (int i = 1; i < 6; i++) begin
         waitGrant(20, lat);
         checkOutput("rr_spacing", lat, 32'd3);
      end
      wrReq = 1'b0;
      rdReq = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] cmd_full backpressure");
      cmdFull = 1'b1;
      applyStimulus(1'b1, 30'h1234, 6'd0, 7'd1, 1'b0, 30'd0, 6'd0, 7'd0);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("full_busy", busy, 1'b0);
      checkOutput("full_cmd_err", cmdErr, 1'b0);
      pushExp(1'b0, 6'd0, 30'h48D0);
      cmdFull = 1'b0;
      waitGrant(20, lat);
      checkOutput("full_release_latency", lat, 32'd1);
      wrReq = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("full_cmd_err_after", cmdErr, 1'b0);

      $display("[TB] cmd_full during issue");
      applyStimulus(1'b1, 30'h10, 6'd1, 7'd2, 1'b0, 30'd0, 6'd0, 7'd0);
      pushExp(1'b0, 6'd1, 30'h40);
      waitGrant(20, lat);
      checkOutput("err_grant_latency", lat, 32'd1);
      cmdFull = 1'b1;
      wrReq = 1'b0;
      @(posedge clk);
      #1;
      cmdFull = 1'b0;
      checkOutput("cmd_err_set", {cmdErr, apCmdErr}, 2'b11);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("cmd_err_sticky", {cmdErr, apCmdErr}, 2'b11);

      $display("[TB] reset during issue");
      applyStimulus(1'b1, 30'h20, 6'd2, 7'd3, 1'b0, 30'd0, 6'd0, 7'd0);
      waitGrant(20, lat);
      checkOutput("abandoned_grant_ack", {cmdEn, wrAck}, 2'b11);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_drop", {cmdEn, wrAck, apCmdEn, apWrAck}, 4'b0000);
      checkResetValues();
      rdReq = 1'b1; rdAddr = 30'h40; rdBl = 6'd0; rdCount = 7'd0;
      @(posedge clk);
      #1;
      pushExp(1'b0, 6'd2, 30'h80);
      rst_n = 1'b1;
      waitGrant(20, lat);
      checkOutput("post_reset_latency", lat, 32'd1);
      wrReq = 1'b0;
      rdReq = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] address wrap and full-size burst");
      applyStimulus(1'b1, 30'h3FFF_FFFF, 6'd63, 7'd64, 1'b0, 30'd0, 6'd0, 7'd0);
      pushExp(1'b0, 6'd63, 30'h3FFF_FFFC);
      waitGrant(20, lat);
      checkOutput("wrap_latency", lat, 32'd1);
      wrReq = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      checkOutput("queue_drained", expQ.size(), 32'd0);
      checkOutput("idle_end", {idle, apIdle}, 2'b11);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lpddr_cmd_arbiter.md
# lpddr_cmd_arbiter

Shares the single LPDDR memory-controller command port between one write requester and one read requester. It issues a command only when the data for that command is safe to move: the write FIFO already holds the whole burst, or the read FIFO has room for the whole burst. Grants round-robin when both sides are eligible. It sits between the write/read data controllers and the MCB cmd_* port pins.

## Interface
- AUTO_PRECHARGE, 0: drives cmd_instr[1]; 1 selects the auto-precharge command variants.
- FIFO_DEPTH, 64: depth of the MCB read data FIFO, in words.
- clk  in  1  single clock for all logic; also forwarded on cmd_clk.
- rst  in  1  reset, asynchronous, active-low.
- wr_req  in  1  write command request; held high until wr_ack.
- wr_addr  in  30  write word address; stable while wr_req is high.
- wr_bl  in  6  write burst length minus one (0 = 1 word, 63 = 64 words).
- wr_ack  out  1  one-cycle pulse, coincident with cmd_en, for the write command.
- rd_req, rd_addr, rd_bl, rd_ack: read-side equivalents of the four write ports.
- wr_count  in  7  MCB write FIFO occupancy, in words.
- rd_count  in  7  MCB read FIFO occupancy, in words.
- cmd_clk  out  1  equal to clk.
- cmd_en  out  1  command strobe.
- cmd_instr  out  3  command code: {1'b0, AUTO_PRECHARGE, is_read}.
- cmd_bl  out  6  burst length of the issued command.
- cmd_byte_addr  out  30  byte address of the issued command.
- cmd_full  in  1  MCB command FIFO full.
- cmd_empty  in  1  MCB command FIFO empty; used only for the idle output.
- last_rd  out  1  1 when the most recent grant went to read.
- busy  out  1  state is not IDLE.
- idle  out  1  state is IDLE, no request is pending, and cmd_empty is high.
- cmd_err  out  1  sticky; set if cmd_full is high in a cycle where cmd_en is high.

## Operation
- The FSM has three states: IDLE, ISSUE and GAP. All outputs are registered.
- Eligibility is evaluated in IDLE only:
  - wr_ok = wr_req & (wr_count >= wr_bl+1). Compare at 7 bits.
  - rd_ok = rd_req & ((FIFO_DEPTH - rd_count) >= rd_bl+1). Compare at 8 bits so there is no underflow when rd_count > FIFO_DEPTH.
- Grant selection in IDLE, when cmd_full is low:
  - Only one side eligible: grant that side.
  - Both eligible: grant the side that was not granted last (last_rd = 1 → write wins).
  - Neither eligible: stay in IDLE.
- Grant action, on entering ISSUE:
  - cmd_en = 1 and the ack for the granted side = 1.
  - cmd_bl = granted bl.
  - cmd_byte_addr = {addr[27:0], 2'b00}; the top two address bits are truncated.
  - cmd_instr[0] = 1 for read, 0 for write.
  - last_rd updates.
- ISSUE lasts one cycle, then GAP. GAP lasts one cycle with cmd_en = 0, then IDLE.
- cmd_full high in IDLE: no grant, no ack, stay in IDLE. Requests remain pending.
- When cmd_en drops, cmd_bl, cmd_byte_addr and cmd_instr hold their last values.
- A request dropped before ack is legal. It is simply not served and causes no error.
- Reset (rst low, at any time, including mid-ISSUE):
  - Immediately: cmd_en = 0, wr_ack = rd_ack = 0, cmd_bl = 0, cmd_byte_addr = 0, cmd_instr = {0, AUTO_PRECHARGE, 0}, last_rd = 1, busy = 0, cmd_err = 0, state = IDLE.
  - A command interrupted by reset is abandoned and never re-issued.
- cmd_err clears only on reset.

## Timing
- Request sampled eligible in IDLE at edge N → cmd_en and ack high during cycle N+1 → GAP during N+2 → IDLE during N+3.
- Minimum command spacing is 3 cycles. Requesters have the GAP cycle to update or drop req, addr and bl.
- The requester must deassert req, or present a new request, by the edge ending GAP. A req still high in IDLE is treated as a new request.
- cmd_en is never high for two consecutive cycles.
- Boundary cases:
  - wr_count == wr_bl+1 is eligible.
  - rd_count == FIFO_DEPTH-(rd_bl+1) is eligible.
  - wr_bl = 63 with wr_count = 64 is eligible.

## Test plan
- Write only: wr_req=1, wr_addr=0x100, wr_bl=15, wr_count=16 → one cycle later cmd_en=1, wr_ack=1, cmd_instr=000, cmd_bl=15, cmd_byte_addr=0x400. With wr_count=15 instead, no command is issued.
- Read room check: rd_req=1, rd_bl=31, rd_count=33 → no grant. rd_count drops to 32 → cmd_en with cmd_instr=001. With AUTO_PRECHARGE=1, cmd_instr=011.
- Both eligible continuously for 6 grants from reset → order W, R, W, R, W, R. cmd_en pulses exactly 3 cycles apart, and acks match the instr bit.
- cmd_full=1 for 10 cycles with wr_req pending → no cmd_en or ack. Command issues 1 cycle after cmd_full falls. cmd_err stays 0. Forcing cmd_full=1 during an ISSUE cycle sets cmd_err, which stays set until reset.
- rst asserted low during ISSUE → cmd_en and ack drop asynchronously, before the next edge, and all outputs take their reset values. After release with req still held, a fresh grant issues; last_rd=1, so write wins a tie.
- Address wrap: wr_addr=0x3FFFFFFF → cmd_byte_addr=0x3FFFFFFC.
